// File: rtl/pipelined_ripple_adder.sv
// Pipelined ripple-carry adder/subtractor split into STAGES chunks of WIDTH/STAGES bits.
// Latency: exactly STAGES cycles. Throughput: one operation per cycle.
// Backpressure: none. Every accepted operation emerges STAGES cycles later and must be taken.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   in_valid, Sub, Cin    issue strobe; Sub=1 selects A-B (Cin ignored), else A+B+Cin
//   A, B                  WIDTH-bit operands
//   out_valid             Sum/Cout/Ovf carry a new result this cycle
//   Sum, Cout, Ovf        result mod 2^WIDTH, MSB carry (1 = no borrow on subtract), signed overflow
module pipelined_ripple_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             Sub,
  input  logic             Cin,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf
);

  localparam int CW = WIDTH / STAGES;

  logic [WIDTH-1:0]           bx;
  logic                       c0;
  logic [STAGES-1:0]          stage_vld;   // valid bit entering stage k this cycle
  logic [STAGES-1:0]          stage_cin;   // carry entering stage k this cycle
  logic [STAGES-1:0][CW-1:0]  a_at;        // chunk k of A after k cycles of skew
  logic [STAGES-1:0][CW-1:0]  b_at;        // chunk k of Bx after k cycles of skew
  logic [STAGES-1:0][CW-1:0]  chunk_sum;
  logic [STAGES-1:0]          chunk_cout;

  logic [STAGES-1:0]          v_q, v_d;
  logic [STAGES-1:0]          c_q, c_d;
  logic                       ovf_q, ovf_d;

  // Subtract is A + ~B + 1, so Cin is replaced by the forced 1.
  assign bx = Sub ? ~B : B;
  assign c0 = Sub | Cin;

  always_comb begin
    stage_vld[0] = in_valid;
    stage_cin[0] = c0;
    for (int k = 1; k < STAGES; k++) begin
      stage_vld[k] = v_q[k-1];
      stage_cin[k] = c_q[k-1];
    end
  end

  always_comb begin
    chunk_sum  = '0;
    chunk_cout = '0;
    for (int k = 0; k < STAGES; k++) begin
      {chunk_cout[k], chunk_sum[k]} = {1'b0, a_at[k]} + {1'b0, b_at[k]} + {{CW{1'b0}}, stage_cin[k]};
    end
  end

  // Valid bits always shift; carries and overflow only load behind a valid
  // bit so the output side holds the last result across bubbles.
  always_comb begin
    v_d   = stage_vld;
    c_d   = c_q;
    ovf_d = ovf_q;
    for (int k = 0; k < STAGES; k++) begin
      if (stage_vld[k]) c_d[k] = chunk_cout[k];
    end
    // The top chunk's operand MSBs arrive here through the skew registers.
    if (stage_vld[STAGES-1]) begin
      ovf_d = (a_at[STAGES-1][CW-1] == b_at[STAGES-1][CW-1]) &&
              (chunk_sum[STAGES-1][CW-1] != a_at[STAGES-1][CW-1]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v_q   <= '0;
      c_q   <= '0;
      ovf_q <= 1'b0;
    end else begin
      v_q   <= v_d;
      c_q   <= c_d;
      ovf_q <= ovf_d;
    end
  end

  assign out_valid = v_q[STAGES-1];
  assign Cout      = c_q[STAGES-1];
  assign Ovf       = ovf_q;

  // Per chunk k: k skew registers ahead of its adder, then a chain of
  // STAGES-k sum registers (the adder's own register plus deskew). A register
  // sitting at pipeline position p loads only when stage_vld[p] is set.
  for (genvar k = 0; k < STAGES; k++) begin : g_chunk
    localparam int DS = STAGES - k;

    logic [DS-1:0][CW-1:0] s_q, s_d;

    if (k == 0) begin : g_no_skew
      assign a_at[k] = A[CW-1:0];
      assign b_at[k] = bx[CW-1:0];
    end else begin : g_skew
      logic [k-1:0][CW-1:0] a_q, a_d, b_q, b_d;

      always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (stage_vld[0]) begin
          a_d[0] = A[k*CW +: CW];
          b_d[0] = bx[k*CW +: CW];
        end
        for (int j = 1; j < k; j++) begin
          if (stage_vld[j]) begin
            a_d[j] = a_q[j-1];
            b_d[j] = b_q[j-1];
          end
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          a_q <= '0;
          b_q <= '0;
        end else begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end

      assign a_at[k] = a_q[k-1];
      assign b_at[k] = b_q[k-1];
    end

    always_comb begin
      s_d = s_q;
      if (stage_vld[k]) s_d[0] = chunk_sum[k];
      for (int j = 1; j < DS; j++) begin
        if (stage_vld[k+j]) s_d[j] = s_q[j-1];
      end
    end

    always_ff @(posedge clk) begin
      if (reset) s_q <= '0;
      else       s_q <= s_d;
    end

    assign Sum[k*CW +: CW] = s_q[DS-1];
  end

endmodule

// File: doc/pipelined_ripple_adder.md
# pipelined_ripple_adder

Parametrised, pipelined successor to the 8-bit ripple-carry adder.
- The WIDTH-bit carry chain is split into STAGES equal chunks, with a register after each chunk, so a new add or subtract can be issued every clock.
- Adds carry-in, a subtract mode, signed overflow, and a valid flag that travels with each result.
- Used as the datapath arithmetic primitive wherever a WIDTH > 8 add would otherwise limit the clock rate.

## Interface
Parameters:
- WIDTH, 16, operand/result width in bits; must be divisible by STAGES.
- STAGES, 4, number of pipeline stages; 1 ≤ STAGES ≤ WIDTH. Chunk width CW = WIDTH/STAGES.

Ports:
- clk  input  1  rising-edge clock; the single clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  A, B, Cin, Sub are sampled this cycle.
- Sub  input  1  0 = add (A+B+Cin), 1 = subtract (A−B); Cin ignored when Sub=1.
- Cin  input  1  carry-in for add.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- out_valid  output  1  Sum/Cout/Ovf hold a new result this cycle.
- Sum  output  WIDTH  result modulo 2^WIDTH.
- Cout  output  1  carry out of the MSB; in subtract mode, 1 = no borrow.
- Ovf  output  1  two's-complement signed overflow.

## Operation
- Effective operands:
  - Bx = Sub ? ~B : B.
  - c0 = Sub ? 1 : Cin.
  - Result = A + Bx + c0, evaluated over WIDTH+1 bits.
- Stage k (0..STAGES−1) adds chunk k: bits [k·CW +: CW] of A and Bx, plus the carry registered out of stage k−1 (c0 for stage 0).
- Skew: the chunk-k bits of A and Bx are delayed k cycles by input shift registers, so each chunk meets its carry.
- Deskew: the chunk-k sum is delayed STAGES−1−k cycles, so all chunks of an operation leave together.
- Cout = carry out of the last chunk.
- Ovf = (A[W−1] == Bx[W−1]) && (Sum[W−1] != A[W−1]).
  - A[W−1] and Bx[W−1] are the values carried through the skew registers.
- Valid pipeline: in_valid is shifted through STAGES registers; the last one drives out_valid.
- Data registers at each stage load only when that stage's incoming valid bit is 1; otherwise they hold.
  - Consequence: while out_valid=0, Sum/Cout/Ovf hold the last valid result.
- No backpressure: every accepted operation emerges exactly STAGES cycles later; the consumer must always accept.
- Operations never interact; each carries its own Sub/Cin.

## Timing
- Latency: exactly STAGES cycles. in_valid=1 at rising edge n gives out_valid=1 after edge n+STAGES.
- Throughput: 1 operation per cycle. Back-to-back in_valid produces back-to-back out_valid in the same order.
- Bubbles: in_valid=0 cycles appear as out_valid=0 cycles at the same relative positions.
- STAGES=1: no skew or deskew registers; the result is registered once, latency 1.
- Reset is sampled on a rising edge:
  - All valid bits, skew/deskew registers, carries, Sum, Cout and Ovf are cleared to 0.
  - After the edge: out_valid=0, Sum=0, Cout=0, Ovf=0.
- Reset mid-operation: all in-flight operations are discarded; none emerge afterwards.
- reset and in_valid both 1 in the same cycle: reset wins and the operand is dropped.
- First in_valid accepted is on the edge after reset deasserts.
- Wrap-around:
  - The sum is modulo 2^WIDTH.
  - A carry must propagate across every chunk boundary; there is no per-chunk truncation.

## Test plan
- WIDTH=8, STAGES=2, add, Cin=0: A=0x71, B=0xCE → two cycles later out_valid=1, Sum=0x3F, Cout=1, Ovf=0. Also A=0x6C, B=0x23 → Sum=0x8F, Cout=0, Ovf=1.
- WIDTH=8, STAGES=2, Sub=1: A=0x1C, B=0x4B → Sum=0xD1, Cout=0 (borrow), Ovf=0. Also A=0x4B, B=0x1C → Sum=0x2F, Cout=1.
- Default 16/4, carry chain through all chunks: A=0xFFFF, B=0x0001, Cin=0 → Sum=0x0000, Cout=1, Ovf=0, four cycles after issue. Also A=0x0000, B=0xFFFF, Cin=1 → Sum=0x0000, Cout=1.
- Default 16/4, throughput:
  - Stimulus: 10 back-to-back random operations (mixed Sub/Cin) with one bubble at op 5.
  - Required: results match a reference model, in order, with one out_valid=0 gap at the matching position.
  - Required: Sum holds during the gap.
- Reset:
  - Assert reset for 1 cycle while 3 operations are in flight. Required: out_valid=0 and Sum=Cout=Ovf=0 after that edge, and no stale result emerges afterwards.
  - Assert reset together with in_valid=1. Required: that operand never appears.
- Parameter sweep:
  - Configurations: STAGES=1, 2 and 8 at WIDTH=8; STAGES=16 at WIDTH=16.
  - Required: latency equals STAGES, and exhaustive (WIDTH=8) or 1000-random (WIDTH=16) results match A+Bx+c0.
